// File: rtl/perclos_alarm_ctrl.sv
// perclos_alarm_ctrl: per-frame fatigue sequencer for both eyes.
// Learns an open-eye baseline height per eye, classifies each valid frame
// as closed/open, keeps a sliding PERCLOS window of closed frames, and
// drives a pulsed buzzer while in ALARM with a minimum hold time.
// Optional feature macro: PERCLOS_RECAL_EN (recal pulse restarts calibration).
module perclos_alarm_ctrl #(
  parameter int CALIB_FRAMES = 16,
  parameter int WIN          = 32,
  parameter int CLOSE_TH     = 12,
  parameter int CLOSE_SHIFT  = 2,
  parameter int BEEP_HALF    = 12_500_000,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic        module_clk,
  input  logic        module_rst_n,
  input  logic [10:0] lcd_pixel_xpos,
  input  logic [10:0] lcd_pixel_ypos,
  input  logic [10:0] eye1_high,
  input  logic [10:0] eye2_high,
  input  logic [10:0] eye1_wide,
  input  logic [10:0] eye2_wide,
  input  logic        recal,
  output logic        beep,
  output logic        calib_done,
  output logic [6:0]  perclos_cnt,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_CALIB   = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;

  localparam int CW = $clog2(CALIB_FRAMES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BEEP_HALF + 1);

  logic           at_origin, prev_origin, tick_q;
  logic           recal_hit;
  logic [10:0]    base1, base2;
  logic [WIN-1:0] win;
  logic [CW-1:0]  calib_cnt;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [BW-1:0]  beep_cnt;
  logic [13:0]    h1_sh, h2_sh;
  logic           closed, frame_go;
  logic [6:0]     cnt_next;

`ifdef PERCLOS_RECAL_EN
  assign recal_hit = recal;
`else
  // Port kept for pin compatibility; calibration only follows reset.
  logic recal_unused;
  assign recal_unused = recal;
  assign recal_hit    = 1'b0;
`endif

  assign at_origin = (lcd_pixel_xpos == 11'd0) && (lcd_pixel_ypos == 11'd0);

  // Rising-edge detect of the frame origin, registered into a one-cycle tick.
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      prev_origin <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      prev_origin <= at_origin;
      tick_q      <= at_origin && !prev_origin;
    end
  end

  // Frame classification and next window count; widened so no shifted bits are lost.
  always_comb begin
    h1_sh    = 14'(eye1_high) << CLOSE_SHIFT;
    h2_sh    = 14'(eye2_high) << CLOSE_SHIFT;
    closed   = (h1_sh < 14'(base1)) && (h2_sh < 14'(base2));
    frame_go = tick_q && (eye1_wide != 11'd0) && (eye2_wide != 11'd0) && !recal_hit;
    cnt_next = perclos_cnt + {6'd0, closed} - {6'd0, win[WIN-1]};
    hold_nx  = (hold_cnt == HW'(HOLD_FRAMES)) ? hold_cnt : hold_cnt + 1'b1;
  end

  // Main sequencer: calibration, PERCLOS window, alarm hold and buzzer cadence.
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      state       <= ST_CALIB;
      beep        <= 1'b0;
      calib_done  <= 1'b0;
      perclos_cnt <= 7'd0;
      base1       <= 11'd0;
      base2       <= 11'd0;
      win         <= '0;
      calib_cnt   <= '0;
      hold_cnt    <= '0;
      beep_cnt    <= '0;
    end else if (recal_hit) begin
      state       <= ST_CALIB;
      beep        <= 1'b0;
      calib_done  <= 1'b0;
      perclos_cnt <= 7'd0;
      base1       <= 11'd0;
      base2       <= 11'd0;
      win         <= '0;
      calib_cnt   <= '0;
      hold_cnt    <= '0;
      beep_cnt    <= '0;
    end else begin
      // Free-running buzzer cadence while alarmed; frame events below override it.
      if (state == ST_ALARM) begin
        if (beep_cnt == BW'(BEEP_HALF - 1)) begin
          beep_cnt <= '0;
          beep     <= ~beep;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
      end
      if (frame_go) begin
        case (state)
          ST_CALIB: begin
            if (eye1_high > base1) base1 <= eye1_high;
            if (eye2_high > base2) base2 <= eye2_high;
            calib_cnt <= calib_cnt + 1'b1;
            if (calib_cnt == CW'(CALIB_FRAMES - 1)) begin
              state      <= ST_MONITOR;
              calib_done <= 1'b1;
            end
          end
          ST_MONITOR: begin
            win         <= {win[WIN-2:0], closed};
            perclos_cnt <= cnt_next;
            if (cnt_next >= 7'(CLOSE_TH)) begin
              state    <= ST_ALARM;
              hold_cnt <= '0;
              beep     <= 1'b1;
              beep_cnt <= '0;
            end
          end
          ST_ALARM: begin
            win         <= {win[WIN-2:0], closed};
            perclos_cnt <= cnt_next;
            hold_cnt    <= hold_nx;
            // A still-high count keeps the alarm even once the hold has expired.
            if ((hold_nx >= HW'(HOLD_FRAMES)) && (cnt_next < 7'(CLOSE_TH))) begin
              state    <= ST_MONITOR;
              beep     <= 1'b0;
              beep_cnt <= '0;
            end
          end
          default: state <= ST_CALIB;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perclos_alarm_ctrl.sv
// Directed bench for perclos_alarm_ctrl with hand-computed expectations.
// Uses BEEP_HALF=4 so the buzzer cadence is observable in a few cycles.
module tb_perclos_alarm_ctrl;

  logic        clk, rst_n;
  logic [10:0] xpos, ypos, h1, h2, w1, w2;
  logic        recal;
  logic        beep, calib_done;
  logic [6:0]  perclos_cnt;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  perclos_alarm_ctrl #(
    .CALIB_FRAMES(16), .WIN(32), .CLOSE_TH(12), .CLOSE_SHIFT(2),
    .BEEP_HALF(4), .HOLD_FRAMES(30)
  ) dut (
    .module_clk(clk), .module_rst_n(rst_n),
    .lcd_pixel_xpos(xpos), .lcd_pixel_ypos(ypos),
    .eye1_high(h1), .eye2_high(h2), .eye1_wide(w1), .eye2_wide(w2),
    .recal(recal), .beep(beep), .calib_done(calib_done),
    .perclos_cnt(perclos_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present the frame origin for one cycle with the given eye measurements.
  task automatic frame_start(input int a, input int b, input bit valid);
    h1 = 11'(a); h2 = 11'(b);
    w1 = valid ? 11'd20 : 11'd0;
    w2 = 11'd20;
    xpos = 11'd0; ypos = 11'd0;
    @(negedge clk);
    xpos = 11'd5;
  endtask

  task automatic frames(input int n, input int a, input int b, input bit valid);
    for (int i = 0; i < n; i++) begin
      frame_start(a, b, valid);
      idle(3);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_beep", 32'(beep), 0);
    chk("rst_calib_done", 32'(calib_done), 0);
    chk("rst_perclos", 32'(perclos_cnt), 0);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; recal = 1'b0;
    xpos = 11'd5; ypos = 11'd5;
    h1 = '0; h2 = '0; w1 = '0; w2 = '0;
    idle(1);
    do_reset();

    // Calibration with invalid frames interleaved (their large heights must be ignored).
    frames(8, 40, 36, 1'b1);
    frames(3, 100, 100, 1'b0);
    frames(7, 40, 36, 1'b1);
    chk("calib_15_state", 32'(state), 0);
    chk("calib_15_done", 32'(calib_done), 0);
    frames(1, 40, 36, 1'b1);
    chk("calib_16_state", 32'(state), 1);
    chk("calib_16_done", 32'(calib_done), 1);
    chk("calib_16_perclos", 32'(perclos_cnt), 0);

    // 10<<2 == 40 is not below base1=40; 9<<2 == 36 is not below base2=36.
    frames(4, 10, 8, 1'b1);
    chk("edge_b1_perclos", 32'(perclos_cnt), 0);
    frames(2, 8, 9, 1'b1);
    chk("edge_b2_perclos", 32'(perclos_cnt), 0);

    // One eye closed only: never counted.
    frames(40, 5, 36, 1'b1);
    chk("one_eye_perclos", 32'(perclos_cnt), 0);
    chk("one_eye_state", 32'(state), 1);

    // Both eyes closed: alarm on the 12th frame.
    frames(11, 5, 5, 1'b1);
    chk("closed11_perclos", 32'(perclos_cnt), 11);
    chk("closed11_state", 32'(state), 1);
    frame_start(5, 5, 1'b1);
    waited = 0;
    while (state != 2'd2 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("alarm_enter_timeout", 32'(waited < 10), 1);
    chk("alarm_perclos", 32'(perclos_cnt), 12);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("beep_k%0d", k), 32'(beep), (k < 4 || k == 8) ? 1 : 0);
      @(negedge clk);
    end

    // Reopen: 12 closed bits drain after 20 open frames; hold expires on the 30th.
    frames(29, 40, 36, 1'b1);
    chk("open29_state", 32'(state), 2);
    chk("open29_perclos", 32'(perclos_cnt), 3);
    frames(1, 40, 36, 1'b1);
    chk("open30_state", 32'(state), 1);
    chk("open30_beep", 32'(beep), 0);
    chk("open30_perclos", 32'(perclos_cnt), 2);
    frames(2, 40, 36, 1'b1);
    chk("drained_perclos", 32'(perclos_cnt), 0);

    // Hold long expired but count still high: stay in ALARM until count drops.
    frames(40, 5, 5, 1'b1);
    chk("full_state", 32'(state), 2);
    chk("full_perclos", 32'(perclos_cnt), 32);
    frames(20, 40, 36, 1'b1);
    chk("drain20_state", 32'(state), 2);
    chk("drain20_perclos", 32'(perclos_cnt), 12);
    frames(1, 40, 36, 1'b1);
    chk("drain21_state", 32'(state), 1);
    chk("drain21_perclos", 32'(perclos_cnt), 11);

    // Oldest 11 window bits are closed: 11 closed frames keep the count, 12th raises it.
    frames(11, 5, 5, 1'b1);
    chk("refill11_perclos", 32'(perclos_cnt), 11);
    frames(1, 5, 5, 1'b1);
    chk("refill12_perclos", 32'(perclos_cnt), 12);
    chk("refill12_state", 32'(state), 2);

    // Recalibration pulse during ALARM.
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    idle(2);
`ifdef PERCLOS_RECAL_EN
    chk("recal_state", 32'(state), 0);
    chk("recal_beep", 32'(beep), 0);
    chk("recal_perclos", 32'(perclos_cnt), 0);
    chk("recal_calib_done", 32'(calib_done), 0);
`else
    chk("recal_state", 32'(state), 2);
    chk("recal_perclos", 32'(perclos_cnt), 12);
    chk("recal_calib_done", 32'(calib_done), 1);
`endif

    // All-zero heights during calibration: baseline 0, nothing can be closed.
    do_reset();
    frames(16, 0, 0, 1'b1);
    chk("zero_calib_state", 32'(state), 1);
    frames(12, 0, 0, 1'b1);
    chk("zero_perclos", 32'(perclos_cnt), 0);
    chk("zero_state", 32'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
